// File: rtl/cnn_pkg.sv
// Shared CNN datapath package: MAC defaults plus a round/shift/saturate helper
// reused by the MAC, pooling and requantisation blocks.
package cnn_pkg;

  localparam int MAC_DATA_W    = 16;
  localparam int MAC_ACC_W     = 40;
  localparam int MAC_LANES     = 4;
  localparam int MAC_FRAC_BITS = 8;
  // Working width of sat_round; callers sign-extend into it, so ACC_W must stay below it.
  localparam int SAT_CALC_W    = 64;

  typedef struct packed {
    logic signed [SAT_CALC_W-1:0] value;
    logic                         sat;
  } sat_res_t;

  // Round half up, arithmetic shift by frac, clamp to a signed data_w range.
  function automatic sat_res_t sat_round(input logic signed [SAT_CALC_W-1:0] val,
                                         input int frac,
                                         input int data_w);
    sat_res_t r;
    logic signed [SAT_CALC_W-1:0] rounded;
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    if (frac > 0) begin
      rounded = (val + (64'sd1 <<< (frac - 1))) >>> frac;
    end else begin
      rounded = val;
    end
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    if (rounded > max_v) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if (rounded < min_v) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end else begin
      r.value = rounded;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_accum_if.sv
// Input beat and output result streams of the MAC lane accumulator.
interface mac_lane_accum_if
  import cnn_pkg::*;
#(
  parameter int LANES  = MAC_LANES,
  parameter int DATA_W = MAC_DATA_W
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [LANES*DATA_W-1:0] in_act;
  logic [LANES*DATA_W-1:0] in_wgt;
  logic [LANES*DATA_W-1:0] in_bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_last, in_act, in_wgt, in_bias, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_last, in_act, in_wgt, in_bias, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: S1 product/bias capture, S2 accumulate and rounded/saturated result.
module mac_lane
  import cnn_pkg::*;
#(
  parameter int DATA_W    = MAC_DATA_W,
  parameter int ACC_W     = MAC_ACC_W,
  parameter int FRAC_BITS = MAC_FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              accept,
  input  logic              s1_valid,
  input  logic              s1_last,
  input  logic              s1_first,
  input  logic              s1_relu,
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] wgt,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] res,
  output logic              sat
);
  logic signed [2*DATA_W-1:0] act_x, wgt_x, prod_full;
  logic signed [ACC_W-1:0]    bias_x, sum;
  logic signed [ACC_W-1:0]    prod_q, prod_d, bias_sh_q, bias_sh_d, acc_q, acc_d;
  logic [DATA_W-1:0]          res_q, res_d;
  logic                       sat_q, sat_d;
  sat_res_t                   post;

  // Next-state for both pipeline stages of this lane.
  always_comb begin
    act_x     = (2*DATA_W)'($signed(act));
    wgt_x     = (2*DATA_W)'($signed(wgt));
    prod_full = act_x * wgt_x;
    bias_x    = ACC_W'($signed(bias));
    sum       = (s1_first ? bias_sh_q : acc_q) + prod_q;
    post      = sat_round(SAT_CALC_W'(sum), FRAC_BITS, DATA_W);
    prod_d    = prod_q;
    bias_sh_d = bias_sh_q;
    acc_d     = acc_q;
    res_d     = res_q;
    sat_d     = sat_q;
    if (advance && accept) begin
      prod_d    = ACC_W'(prod_full);
      bias_sh_d = bias_x <<< FRAC_BITS;
    end else begin
      prod_d    = prod_q;
      bias_sh_d = bias_sh_q;
    end
    if (advance && s1_valid) begin
      if (s1_last) begin
        acc_d = {ACC_W{1'b0}};
        // ReLU acts on the already saturated value; saturation is still flagged.
        if (s1_relu && post.value[SAT_CALC_W-1]) begin
          res_d = {DATA_W{1'b0}};
        end else begin
          res_d = DATA_W'(post.value);
        end
        sat_d = sat_q | post.sat;
      end else begin
        acc_d = sum;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= {ACC_W{1'b0}};
      bias_sh_q <= {ACC_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      res_q     <= {DATA_W{1'b0}};
      sat_q     <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      bias_sh_q <= bias_sh_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      sat_q     <= sat_d;
    end
  end

  assign res = res_q;
  assign sat = sat_q;
endmodule

// File: rtl/mac_lane_accum.sv
// Multi-lane pipelined signed fixed-point MAC with windowed accumulation;
// the top owns the shared handshake, window framing and stall control.
module mac_lane_accum
  import cnn_pkg::*;
#(
  parameter int DATA_W    = MAC_DATA_W,
  parameter int ACC_W     = MAC_ACC_W,
  parameter int LANES     = MAC_LANES,
  parameter int FRAC_BITS = MAC_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             relu_en,
  mac_lane_accum_if.slave  bus,
  output logic [LANES-1:0] sat_flag
);
  logic stall, accept, advance;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic s1_relu_q, s1_relu_d, s1_first_q, s1_first_d;
  logic first_q, first_d, out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data;

  // Shared control: a stall freezes every register, including out_valid.
  always_comb begin
    stall       = !ce || (out_valid_q && !bus.out_ready);
    advance     = !stall;
    accept      = bus.in_valid && !stall && !rst;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_relu_d   = s1_relu_q;
    s1_first_d  = s1_first_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q && s1_last_q;
      if (accept) begin
        s1_last_d  = bus.in_last;
        s1_relu_d  = relu_en;
        s1_first_d = first_q;
        first_d    = bus.in_last;
      end else begin
        s1_last_d  = s1_last_q;
        s1_relu_d  = s1_relu_q;
        s1_first_d = s1_first_q;
        first_d    = first_q;
      end
    end else begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
    end
  end

  // Control registers; reset arms the first-beat flag so the next beat adds bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_relu_q   <= s1_relu_d;
      s1_first_q  <= s1_first_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .accept  (accept),
      .s1_valid(s1_valid_q),
      .s1_last (s1_last_q),
      .s1_first(s1_first_q),
      .s1_relu (s1_relu_q),
      .act     (bus.in_act[i*DATA_W +: DATA_W]),
      .wgt     (bus.in_wgt[i*DATA_W +: DATA_W]),
      .bias    (bus.in_bias[i*DATA_W +: DATA_W]),
      .res     (out_data[i*DATA_W +: DATA_W]),
      .sat     (sat_flag[i])
    );
  end

  assign bus.in_ready  = !stall && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data;
endmodule

// File: tb/tb_mac_lane_accum.sv
// Bench for mac_lane_accum: beat table with scoreboarded results, plus
// backpressure, clock-enable and mid-window reset sequences.
module tb_mac_lane_accum;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int W      = LANES * DATA_W;

  typedef struct {
    logic [W-1:0]     act;
    logic [W-1:0]     wgt;
    logic [W-1:0]     bias;
    logic             last;
    logic             relu;
    logic [W-1:0]     exp;
    logic [LANES-1:0] sat_new;
  } vec_t;

  typedef struct {
    logic [W-1:0]     data;
    logic [LANES-1:0] sat;
    int               cyc;
  } exp_t;

  logic             clk, rst, ce, relu_en;
  logic [LANES-1:0] sat_flag;
  exp_t             sb[$];
  vec_t             tbl[13];
  int               n_cmp, n_err, cyc;
  logic [LANES-1:0] sat_acc;

  mac_lane_accum_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  mac_lane_accum #(.DATA_W(16), .ACC_W(40), .LANES(LANES), .FRAC_BITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .relu_en (relu_en),
    .bus     (bus),
    .sat_flag(sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] rep4(input logic [DATA_W-1:0] x);
    return {x, x, x, x};
  endfunction

  function automatic vec_t mk(input logic [W-1:0] act, input logic [W-1:0] wgt,
                              input logic [W-1:0] bias, input logic last, input logic relu,
                              input logic [W-1:0] exp, input logic [LANES-1:0] sat_new);
    vec_t v;
    v.act = act; v.wgt = wgt; v.bias = bias; v.last = last; v.relu = relu;
    v.exp = exp; v.sat_new = sat_new;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    bus.in_act  = v.act;
    bus.in_wgt  = v.wgt;
    bus.in_bias = v.bias;
    bus.in_last = v.last;
    relu_en     = v.relu;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic drive_beat(input vec_t v, input bit chk_lat);
    int   waited;
    exp_t e;
    set_in(v);
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end else if (v.last) begin
      sat_acc = sat_acc | v.sat_new;
      e.data  = v.exp;
      e.sat   = sat_acc;
      e.cyc   = chk_lat ? cyc + 2 : -1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ce && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %h, expected no result", bus.out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("sat_flag", W'(sat_flag), W'(e.sat));
          if (e.cyc >= 0) check("latency_cycle", W'(cyc), W'(e.cyc));
        end
      end
    end
  endtask

  initial begin
    vec_t a, b1, b2, c1, c2, r1, t1, t2, t3;
    int   w;
    n_cmp = 0; n_err = 0; cyc = 0; sat_acc = '0;
    rst = 1'b1; ce = 1'b1; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus.in_act = '0; bus.in_wgt = '0; bus.in_bias = '0;

    fork
      begin forever begin @(posedge clk); cyc++; end end
      begin monitor(); end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    tbl[0]  = mk(rep4(16'h0200), rep4(16'h0080), rep4(16'h0100), 1'b0, 1'b0, '0, 4'b0000);
    tbl[1]  = mk(rep4(16'h0200), rep4(16'h0080), rep4(16'h7FFF), 1'b0, 1'b0, '0, 4'b0000);
    tbl[2]  = mk(rep4(16'h0200), rep4(16'h0080), rep4(16'h7FFF), 1'b1, 1'b0, rep4(16'h0400), 4'b0000);
    tbl[3]  = mk(64'h0100_0200_0300_0400, rep4(16'h0100), '0, 1'b1, 1'b0,
                 64'h0100_0200_0300_0400, 4'b0000);
    tbl[4]  = mk(64'h0000_8000_7FFF_7FFF, rep4(16'h7FFF), '0, 1'b0, 1'b0, '0, 4'b0000);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(64'h0000_8000_7FFF_7FFF, rep4(16'h7FFF), '0, 1'b1, 1'b0,
                 64'h0000_8000_7FFF_7FFF, 4'b0111);
    tbl[8]  = mk(64'h0200_FE00_FE00_FE00, rep4(16'h0100), '0, 1'b1, 1'b1,
                 64'h0200_0000_0000_0000, 4'b0000);
    tbl[9]  = mk(64'h0200_FE00_FE00_FE00, rep4(16'h0100), '0, 1'b1, 1'b0,
                 64'h0200_FE00_FE00_FE00, 4'b0000);
    tbl[10] = mk(64'hFE7F_017F_FFFD_0003, 64'h0001_0001_0080_0080, '0, 1'b1, 1'b0,
                 64'hFFFE_0001_FFFF_0002, 4'b0000);
    tbl[11] = mk(rep4(16'h0100), rep4(16'h0100), 64'hFF00_0000_0100_0200, 1'b0, 1'b1, '0, 4'b0000);
    tbl[12] = mk(rep4(16'h0100), rep4(16'h0100), rep4(16'h7FFF), 1'b1, 1'b0,
                 64'h0100_0200_0300_0400, 4'b0000);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), W'(1'b0));
    check("rst_out_valid", W'(bus.out_valid), W'(1'b0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_sat_flag", W'(sat_flag), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", W'(bus.in_ready), W'(1'b1));
    @(posedge clk);
    #1;

    // Table windows back to back, no stalls: fixed 2-cycle latency each
    for (int i = 0; i < 13; i++) drive_beat(tbl[i], 1'b1);
    drain();

    // Backpressure: result A held while window B is partially accumulated
    a  = mk(64'h0100_0200_0300_0400, rep4(16'h0100), rep4(16'h0100), 1'b1, 1'b0,
            64'h0200_0300_0400_0500, 4'b0000);
    b1 = mk(rep4(16'h0300), rep4(16'h0100), rep4(16'hFF00), 1'b0, 1'b0, '0, 4'b0000);
    b2 = mk(rep4(16'h0100), rep4(16'h0200), rep4(16'h7FFF), 1'b1, 1'b0, rep4(16'h0400), 4'b0000);
    bus.out_ready = 1'b0;
    fork
      begin
        drive_beat(a, 1'b0);
        drive_beat(b1, 1'b0);
        drive_beat(b2, 1'b0);
      end
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.out_valid && w < 20);
        check("bp_out_valid", W'(bus.out_valid), W'(1'b1));
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_in_ready", W'(bus.in_ready), W'(1'b0));
          check("bp_out_data_stable", bus.out_data, 64'h0200_0300_0400_0500);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Clock enable low: presented beat must not be taken, S1 beat must not repeat
    c1 = mk(rep4(16'h0100), rep4(16'h0100), rep4(16'h0100), 1'b0, 1'b0, '0, 4'b0000);
    c2 = mk(rep4(16'h0200), rep4(16'h0100), '0, 1'b1, 1'b0, rep4(16'h0400), 4'b0000);
    drive_beat(c1, 1'b0);
    ce = 1'b0;
    set_in(c2);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ce_in_ready", W'(bus.in_ready), W'(1'b0));
      check("ce_out_valid", W'(bus.out_valid), W'(1'b0));
    end
    @(posedge clk);
    #1;
    ce = 1'b1;
    drive_beat(c2, 1'b0);
    drain();

    // Reset after 2 beats of a 5-beat window discards the partial sum
    r1 = mk(rep4(16'h0100), rep4(16'h0100), rep4(16'h0100), 1'b0, 1'b0, '0, 4'b0000);
    drive_beat(r1, 1'b0);
    drive_beat(r1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", W'(bus.in_ready), W'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    sat_acc = '0;
    @(negedge clk);
    check("midrst_out_valid", W'(bus.out_valid), W'(1'b0));
    check("midrst_out_data", bus.out_data, '0);
    check("midrst_sat_flag", W'(sat_flag), '0);
    @(posedge clk);
    #1;
    t1 = mk(rep4(16'h0100), rep4(16'h0100), rep4(16'h0200), 1'b0, 1'b0, '0, 4'b0000);
    t2 = mk(rep4(16'h0100), rep4(16'h0100), rep4(16'h7FFF), 1'b0, 1'b0, '0, 4'b0000);
    t3 = mk(rep4(16'h0100), rep4(16'h0100), rep4(16'h7FFF), 1'b1, 1'b0, rep4(16'h0500), 4'b0000);
    drive_beat(t1, 1'b1);
    drive_beat(t2, 1'b1);
    drive_beat(t3, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
